// File: rtl/alu_issue.sv
// MIPS decode/issue stage driving the ALU: 1-cycle latency, registered valid/ready output that holds under backpressure.
// `ALU_ISSUE_SKID_EN adds a 1-entry skid buffer so in_ready is registered with no path from out_ready.
module alu_issue #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      i1,
  output logic [31:0]      i2,
  output logic [2:0]       aluop,
  output logic [4:0]       dst,
  output logic             wr_en,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;

  typedef struct packed {
    logic [31:0] i1;
    logic [31:0] i2;
    logic [2:0]  aluop;
    logic [4:0]  dst;
    logic        wr_en;
    logic        illegal;
  } issue_t;

  localparam issue_t RST_ISSUE = '{i1: 32'd0, i2: 32'd0, aluop: OP_ADD, dst: 5'd0, wr_en: 1'b0, illegal: 1'b0};

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] simm;
  logic [31:0] zimm;
  logic [31:0] shamt_ext;
  logic        unused_reg_fields;

  assign opcode            = instr[31:26];
  assign funct             = instr[5:0];
  assign simm              = {{16{instr[15]}}, instr[15:0]};
  assign zimm              = {16'd0, instr[15:0]};
  assign shamt_ext         = {27'd0, instr[10:6]};
  assign unused_reg_fields = ^instr[25:16];

  issue_t dec;

  always_comb begin
    dec = RST_ISSUE;
    if (opcode == 6'h00) begin
      dec.dst   = instr[15:11];
      dec.wr_en = 1'b1;
      dec.i1    = rs_data;
      dec.i2    = rt_data;
      case (funct)
        6'h20, 6'h21: dec.aluop = OP_ADD;
        6'h22, 6'h23: dec.aluop = OP_SUB;
        6'h24:        dec.aluop = OP_AND;
        6'h25:        dec.aluop = OP_OR;
        6'h00: begin
          dec.aluop = OP_SLL;
          dec.i1    = rt_data;
          dec.i2    = shamt_ext;
        end
        6'h02: begin
          dec.aluop = OP_SRL;
          dec.i1    = rt_data;
          dec.i2    = shamt_ext;
        end
        default:      dec.illegal = 1'b1;
      endcase
    end else begin
      dec.dst   = instr[20:16];
      dec.wr_en = 1'b1;
      dec.i1    = rs_data;
      dec.i2    = simm;
      dec.aluop = OP_ADD;
      case (opcode)
        6'h08, 6'h09, 6'h23: dec.aluop = OP_ADD;
        6'h0C: begin
          dec.aluop = OP_AND;
          dec.i2    = zimm;
        end
        6'h0D: begin
          dec.aluop = OP_OR;
          dec.i2    = zimm;
        end
        6'h2B:   dec.wr_en   = 1'b0;
        default: dec.illegal = 1'b1;
      endcase
    end
    // Illegal ops are passed through as an inert add so downstream can trap on them.
    if (dec.illegal) begin
      dec         = RST_ISSUE;
      dec.illegal = 1'b1;
    end
    if (dec.dst == 5'd0) begin
      dec.wr_en = 1'b0;
    end
  end

  state_t state_q, state_d;
  issue_t out_q, out_d;
  logic   in_acc;
  logic   out_fire;
  logic   out_load;
  logic   cand_vld;
  issue_t cand;

  assign in_acc   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_load = (state_q == EMPTY) || out_fire;

`ifdef ALU_ISSUE_SKID_EN
  logic   skid_vld_q, skid_vld_d;
  issue_t skid_q, skid_d;

  assign in_ready = !skid_vld_q;
  // A parked skid entry always goes to the output ahead of new input to keep order.
  assign cand_vld = skid_vld_q || in_acc;
  assign cand     = skid_vld_q ? skid_q : dec;

  always_comb begin
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (skid_vld_q && out_load) begin
      skid_vld_d = 1'b0;
    end else if (in_acc && !out_load) begin
      skid_vld_d = 1'b1;
      skid_d     = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_vld_q <= 1'b0;
      skid_q     <= RST_ISSUE;
    end else begin
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
  assign cand_vld = in_acc;
  assign cand     = dec;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (cand_vld) state_d = FULL;
      FULL:    if (out_fire && !cand_vld) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
  end

  always_comb begin
    out_d = out_q;
    if (out_load && cand_vld) begin
      out_d = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= RST_ISSUE;
    end else begin
      out_q <= out_d;
    end
  end

  assign i1      = out_q.i1;
  assign i2      = out_q.i2;
  assign aluop   = out_q.aluop;
  assign dst     = out_q.dst;
  assign wr_en   = out_q.wr_en;
  assign illegal = out_q.illegal;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_acc && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed decode cases, backpressure, randomized traffic and counter saturation.
module tb_alu_issue;
  localparam int CNT_W = 8;
`ifdef ALU_ISSUE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      i1;
  logic [31:0]      i2;
  logic [2:0]       aluop;
  logic [4:0]       dst;
  logic             wr_en;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  always #5 clk = ~clk;

  alu_issue #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .i1(i1), .i2(i2), .aluop(aluop), .dst(dst), .wr_en(wr_en),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] i1;
    logic [31:0] i2;
    logic [2:0]  aluop;
    logic [4:0]  dst;
    logic        wr_en;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];
  int   model_cnt;

  logic [73:0] dut_vec;
  assign dut_vec = {i1, i2, aluop, dst, wr_en, illegal};

  function automatic logic [73:0] vec(input exp_t e);
    return {e.i1, e.i2, e.aluop, e.dst, e.wr_en, e.illegal};
  endfunction

  // Reference decode straight from the instruction-set table.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    int   s16;
    logic [31:0] sx, zx, sh;
    logic [4:0]  rd, rtn;
    s16 = $signed(w[15:0]);
    sx  = s16;
    zx  = w & 32'h0000FFFF;
    sh  = (w >> 6) & 32'h1F;
    rd  = w[15:11];
    rtn = w[20:16];
    e = '{32'd0, 32'd0, 3'b100, 5'd0, 1'b0, 1'b1};
    if (w[31:26] == 6'h00) begin
      case (w[5:0])
        6'h20, 6'h21: e = '{rs, rt, 3'b100, rd, 1'b1, 1'b0};
        6'h22, 6'h23: e = '{rs, rt, 3'b101, rd, 1'b1, 1'b0};
        6'h24:        e = '{rs, rt, 3'b110, rd, 1'b1, 1'b0};
        6'h25:        e = '{rs, rt, 3'b111, rd, 1'b1, 1'b0};
        6'h00:        e = '{rt, sh, 3'b000, rd, 1'b1, 1'b0};
        6'h02:        e = '{rt, sh, 3'b001, rd, 1'b1, 1'b0};
        default: ;
      endcase
    end else begin
      case (w[31:26])
        6'h08, 6'h09, 6'h23: e = '{rs, sx, 3'b100, rtn, 1'b1, 1'b0};
        6'h0C:               e = '{rs, zx, 3'b110, rtn, 1'b1, 1'b0};
        6'h0D:               e = '{rs, zx, 3'b111, rtn, 1'b1, 1'b0};
        6'h2B:               e = '{rs, sx, 3'b100, rtn, 1'b0, 1'b0};
        default: ;
      endcase
    end
    if (e.dst == 5'd0) e.wr_en = 1'b0;
    return e;
  endfunction

  logic [5:0] rfn [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h00, 6'h02};
  logic [5:0] iop [6] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h23, 6'h2B};

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 5) begin
      w[31:26] = 6'h00;
      w[5:0]   = rfn[$urandom_range(0, 7)];
    end else if (sel < 9) begin
      w[31:26] = iop[$urandom_range(0, 5)];
    end
    return w;
  endfunction

  task automatic send(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
    instr = w; rs_data = rs; rt_data = rt; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; instr = 32'hFC000000; rs_data = 32'd1; rt_data = 32'd2; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (illegal_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", illegal_cnt); end
    checks++; if (aluop !== 3'b100) begin errors++; $display("FAIL reset_aluop: got %b expected 100", aluop); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if ({i1, i2, dst, wr_en, illegal} !== 71'd0) begin
      errors++; $display("FAIL reset_fields: got %h expected 0", {i1, i2, dst, wr_en, illegal});
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    send(32'h014B4820, 32'd5, 32'd7);
    checks++; if ({out_valid, dut_vec} !== {1'b1, 32'd5, 32'd7, 3'b100, 5'd9, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add: got %b_%h expected 1_%h", out_valid, dut_vec, {32'd5, 32'd7, 3'b100, 5'd9, 1'b1, 1'b0});
    end
    send(32'h014B4822, 32'd9, 32'd4);
    checks++; if (dut_vec !== {32'd9, 32'd4, 3'b101, 5'd9, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub: got %h", dut_vec);
    end
    send(32'h000A4880, 32'hDEAD, 32'h11);
    checks++; if (dut_vec !== {32'h11, 32'd2, 3'b000, 5'd9, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sll: got %h", dut_vec);
    end
    send(32'h000A4882, 32'hDEAD, 32'h80);
    checks++; if (dut_vec !== {32'h80, 32'd2, 3'b001, 5'd9, 1'b1, 1'b0}) begin
      errors++; $display("FAIL srl: got %h", dut_vec);
    end
    send(32'h00000000, 32'h0, 32'h0);
    checks++; if (dut_vec !== {32'h0, 32'd0, 3'b000, 5'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL nop: got %h", dut_vec);
    end
    send(32'h014B0020, 32'd1, 32'd2);
    checks++; if (dut_vec !== {32'd1, 32'd2, 3'b100, 5'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_r0: got %h", dut_vec);
    end
    send(32'h014B4827, 32'd1, 32'd2);
    checks++; if (dut_vec !== {32'd0, 32'd0, 3'b100, 5'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL bad_funct: got %h", dut_vec);
    end
    checks++; if (illegal_cnt !== 8'd1) begin errors++; $display("FAIL bad_funct_cnt: got %0d expected 1", illegal_cnt); end
  endtask

  task automatic test_itype();
    send(32'h2128FFFF, 32'd3, 32'd0);
    checks++; if (dut_vec !== {32'd3, 32'hFFFFFFFF, 3'b100, 5'd8, 1'b1, 1'b0}) begin
      errors++; $display("FAIL addi: got %h", dut_vec);
    end
    send(32'h3128FFFF, 32'd3, 32'd0);
    checks++; if (dut_vec !== {32'd3, 32'h0000FFFF, 3'b110, 5'd8, 1'b1, 1'b0}) begin
      errors++; $display("FAIL andi: got %h", dut_vec);
    end
    send(32'hAD2A0004, 32'h100, 32'd0);
    checks++; if (dut_vec !== {32'h100, 32'd4, 3'b100, 5'd10, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sw: got %h", dut_vec);
    end
    send(32'h8D2A0004, 32'h100, 32'd0);
    checks++; if (dut_vec !== {32'h100, 32'd4, 3'b100, 5'd10, 1'b1, 1'b0}) begin
      errors++; $display("FAIL lw: got %h", dut_vec);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    logic exp_rdy;
    int   k = 0;
    exp_t e;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h21080000; rs_data = 32'd100; rt_data = 32'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c > 0) begin
        checks++; if (!(out_valid === 1'b1 && i1 === 32'd100 && i2 === 32'd0 && dst === 5'd8)) begin
          errors++; $display("FAIL hold_stable c%0d: got v=%b i1=%0d i2=%0d dst=%0d expected v=1 i1=100 i2=0 dst=8", c, out_valid, i1, i2, dst);
        end
        exp_rdy = (SKID && c == 1);
        checks++; if (in_ready !== exp_rdy) begin
          errors++; $display("FAIL hold_in_ready c%0d: got %b expected %b", c, in_ready, exp_rdy);
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin exp_q.push_back(model(instr, rs_data, rt_data)); k++; end
      @(posedge clk); #1;
      if (acc) begin instr = 32'h21080000 | k; rs_data = 100 + k; end
    end
    checks++; if (k != (SKID ? 2 : 1)) begin
      errors++; $display("FAIL hold_accepts: got %0d expected %0d", k, SKID ? 2 : 1);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL release_bubble c%0d: got out_valid=%b expected 1", c, out_valid);
        end else begin
          e = exp_q.pop_front();
          if (dut_vec !== vec(e)) begin errors++; $display("FAIL release_order c%0d: got %h expected %h", c, dut_vec, vec(e)); end
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin exp_q.push_back(model(instr, rs_data, rt_data)); k++; end
      @(posedge clk); #1;
      if (acc) begin instr = 32'h21080000 | k; rs_data = 100 + k; end
      if (c == 5) in_valid = 1'b0;
    end
    checks++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL release_drain: got %0d left, out_valid=%b expected 0 left, 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_random();
    logic acc;
    exp_t e;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++; if (illegal_cnt !== model_cnt[CNT_W-1:0]) begin
        errors++; $display("FAIL rand_cnt c%0d: got %0d expected %0d", c, illegal_cnt, model_cnt);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious c%0d: got out_valid=1 expected 0", c);
        end else begin
          e = exp_q.pop_front();
          if (dut_vec !== vec(e)) begin errors++; $display("FAIL rand_data c%0d: got %h expected %h", c, dut_vec, vec(e)); end
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        e = model(instr, rs_data, rt_data);
        exp_q.push_back(e);
        if (e.illegal && model_cnt < 255) model_cnt++;
      end
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      instr     = rand_instr();
      rs_data   = $urandom;
      rt_data   = $urandom;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (dut_vec !== vec(e)) begin errors++; $display("FAIL rand_drain: got %h expected %h", dut_vec, vec(e)); end
      end
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rand_empty: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_saturate();
    int accepts = 0;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 302; c++) begin
      instr = {6'h3F, 26'($urandom)}; rs_data = $urandom; rt_data = $urandom;
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++; if (dut_vec !== {64'd0, 3'b100, 5'd0, 1'b0, 1'b1}) begin
          errors++; $display("FAIL sat_fields c%0d: got %h expected illegal inert op", c, dut_vec);
        end
      end
      checks++; if (illegal_cnt !== model_cnt[CNT_W-1:0]) begin
        errors++; $display("FAIL sat_cnt c%0d: got %0d expected %0d", c, illegal_cnt, model_cnt);
      end
      if (in_ready === 1'b1) begin
        accepts++;
        if (model_cnt < 255) model_cnt++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (illegal_cnt !== 8'd255 || accepts < 300) begin
      errors++; $display("FAIL sat_final: got cnt=%0d accepts=%0d expected 255 and >=300", illegal_cnt, accepts);
    end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    instr = 32'h014B4820; rs_data = 32'd5; rt_data = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_setup: got %b expected 1", out_valid); end
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid, i1, illegal_cnt} !== 41'd0) begin
      errors++; $display("FAIL flush: got v=%b i1=%0d cnt=%0d expected all 0", out_valid, i1, illegal_cnt);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after: got %b expected 0", out_valid); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0; model_cnt = 0;
    test_reset();
    test_rtype();
    test_itype();
    test_backpressure();
    test_random();
    test_saturate();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage that drives the execute-stage ALU.
- Accepts one 32-bit MIPS instruction per handshake, together with its register-file read data (rs/rt).
- Decodes the instruction into the ALU's 3-bit aluop and selects the operands (register value, sign- or zero-extended immediate, or shamt).
- Presents the result to the ALU and writeback through a registered valid/ready output stage; flags illegal encodings and counts them.

Parameters:
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction and operand data valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- instr  in  32  MIPS instruction word.
- rs_data  in  32  register-file value of instr[25:21].
- rt_data  in  32  register-file value of instr[20:16].
- out_valid  out  1  i1/i2/aluop/dst/wr_en/illegal are valid.
- out_ready  in  1  downstream accepts the output this cycle.
- i1  out  32  ALU operand 1.
- i2  out  32  ALU operand 2.
- aluop  out  3  100 add, 101 sub, 110 and, 111 or, 000 sll, 001 srl.
- dst  out  5  destination register: rd for R-type, rt for I-type.
- wr_en  out  1  result is written back.
- illegal  out  1  unsupported opcode or funct.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset, synchronous with rst=1 at the edge:
  - out_valid=0, i1=0, i2=0, aluop=3'b100, dst=0, wr_en=0, illegal=0, illegal_cnt=0.
  - Reset overrides a handshake in the same cycle; an in-flight output is dropped.
- Handshake:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - Latency: 1 cycle. An instruction accepted at edge N is presented with out_valid=1 after edge N.
  - Output registers hold stable while out_valid && !out_ready.
- Output-register state machine, states EMPTY/FULL:
  - EMPTY --accept--> FULL.
  - FULL --out accept, no in accept--> EMPTY.
  - FULL --out accept and in accept in the same cycle--> FULL with the new data (back-to-back throughput of 1 per cycle).
- R-type decode (opcode 0x00), by funct:
  - 0x20/0x21 -> aluop 100, i1=rs_data, i2=rt_data.
  - 0x22/0x23 -> aluop 101, i1=rs_data, i2=rt_data.
  - 0x24 -> aluop 110, i1=rs_data, i2=rt_data.
  - 0x25 -> aluop 111, i1=rs_data, i2=rt_data.
  - 0x00 -> aluop 000, i1=rt_data, i2={27'b0, shamt}.
  - 0x02 -> aluop 001, i1=rt_data, i2={27'b0, shamt}.
  - All R-type: dst=instr[15:11], wr_en=1.
- I-type decode (dst=instr[20:16], i1=rs_data):
  - 0x08/0x09 -> aluop 100, i2=sign-extended imm16, wr_en=1.
  - 0x0C -> aluop 110, i2=zero-extended imm16, wr_en=1.
  - 0x0D -> aluop 111, i2=zero-extended imm16, wr_en=1.
  - 0x23 (lw) -> aluop 100, i2=sign-extended imm16, wr_en=1.
  - 0x2B (sw) -> aluop 100, i2=sign-extended imm16, wr_en=0.
- Illegal encodings (any other opcode, or R-type with any other funct):
  - Output illegal=1, aluop=100, i1=0, i2=0, wr_en=0, dst=0.
  - The instruction is still handshaken through, so downstream can trap.
  - illegal_cnt increments on accept and saturates at all-ones with no wrap.
- Writes to register 0: dst==0 forces wr_en=0.
- Instruction word 0x00000000 decodes as sll $0,$0,0, i.e. a nop with wr_en=0.

Optional Feature:
- Macro: ALU_ISSUE_SKID_EN.
- Defined:
  - Adds a 1-entry skid buffer; in_ready becomes a registered signal = skid buffer empty, with no combinational path from out_ready.
  - While the output holds (out_valid && !out_ready), one further instruction is captured into the skid entry and in_ready drops the next cycle.
  - When the output drains, the skid entry moves to the output first, preserving order.
  - Reset clears the skid entry.
  - Throughput stays 1 per cycle.
- Undefined: single output register, combinational in_ready as specified above.

Test Plan:
- Reset with rst=1 for 2 cycles while in_valid=1 -> out_valid=0, illegal_cnt=0, aluop=100, in_ready=1.
- instr=0x014B4820 (add $9,$10,$11), rs=5, rt=7 -> next cycle out_valid=1, aluop=100, i1=5, i2=7, dst=9, wr_en=1.
- instr=0x2128FFFF (addi $8,$9,-1), rs=3 -> aluop=100, i2=0xFFFFFFFF, dst=8.
  - Same imm with andi (0x3128FFFF) -> aluop=110, i2=0x0000FFFF.
- instr=0x000A4880 (sll $9,$10,2), rt=0x11 -> aluop=000, i1=0x11, i2=2.
  - instr=0xAD2A0004 (sw) -> wr_en=0, i2=4.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0 (skid build: exactly one extra accepted).
  - Release out_ready -> instructions emerge in order, one per cycle.
- 300 accepted instructions with opcode 0x3F -> illegal=1, wr_en=0 on each; illegal_cnt saturates at 255.
